// File: rtl/axil_reg_read_slave_pkg.sv
// Shared constants for the AXI4-Lite register read responder:
// response codes, read-FSM state encodings and the byte-offset helper.
package axil_reg_read_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Number of low address bits that select a byte within one register.
  function automatic int addr_shift(input int data_width);
    return (data_width == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/axil_rd_ctrl.sv
// Read-channel sequencing: AR acceptance, latency timer, R valid.
//
//  state  | meaning
//  S_IDLE | ready for an address (arready high except first cycle out of reset)
//  S_WAIT | address accepted, timer counting down to the data sample point
//  S_RESP | rvalid high, holding the response until rready
module axil_rd_ctrl
  import axil_reg_read_slave_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic arvalid,
  input  logic rready,
  output logic arready,
  output logic rvalid,
  output logic ar_hs,
  output logic load_resp,
  output logic r_hs
);

  logic [1:0] state;
  logic [3:0] cnt;

  assign ar_hs     = (state == S_IDLE) && arvalid && arready;
  assign load_resp = (state == S_WAIT) && (cnt == 4'd0);
  assign r_hs      = rvalid && rready;

  // The timer is loaded with READ_LATENCY on the AR edge; together with the
  // edge that leaves WAIT this puts rvalid READ_LATENCY+1 edges after AR.
  // arready is raised one cycle late out of reset so the first post-reset
  // cycle never accepts an address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ar_hs) begin
            arready <= 1'b0;
            cnt     <= 4'(READ_LATENCY);
            state   <= S_WAIT;
          end else begin
            arready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rvalid <= 1'b1;
            state  <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (r_hs) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          rvalid  <= 1'b0;
          arready <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/axil_reg_read_slave.sv
// AXI4-Lite read responder for a flat register bank: decodes the read
// address, lets axil_rd_ctrl time the response, and returns the register
// value sampled on the edge that enters RESP.
module axil_reg_read_slave
  import axil_reg_read_slave_pkg::*;
#(
  parameter int              ADDR_WIDTH   = 32,
  parameter int              DATA_WIDTH   = 32,
  parameter int              NUM_REGS     = 8,
  parameter longint unsigned BASE_ADDR    = 64'h1000_0000,
  parameter int              READ_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int SH   = addr_shift(DATA_WIDTH);
  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  logic                  ar_hs, load_resp, r_hs;
  logic [ADDR_WIDTH-1:0] off, idx_full;
  logic                  dec_err;
  logic                  err_q;
  logic [IDXW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] reg_sel;

  axil_rd_ctrl #(.READ_LATENCY(READ_LATENCY)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .arvalid   (arvalid),
    .rready    (rready),
    .arready   (arready),
    .rvalid    (rvalid),
    .ar_hs     (ar_hs),
    .load_resp (load_resp),
    .r_hs      (r_hs)
  );

  // Decode is fully unsigned in ADDR_WIDTH bits; the below-base test keeps a
  // wrapped offset from aliasing onto a valid register.
  always_comb begin
    off      = araddr - BASE;
    idx_full = off >> SH;
    dec_err  = (araddr < BASE) || (off[SH-1:0] != '0) ||
               (idx_full >= ADDR_WIDTH'(NUM_REGS));
  end

  assign reg_sel = regs_flat[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

  // Only the decode result is kept at AR time; data is fetched later.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      idx_q <= '0;
    end else if (ar_hs) begin
      err_q <= dec_err;
      idx_q <= idx_full[IDXW-1:0];
    end
  end

  // Response payload loads with rvalid rising and clears on the R handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (load_resp) begin
      rdata <= err_q ? '0 : reg_sel;
      rresp <= err_q ? RESP_SLVERR : RESP_OKAY;
    end else if (r_hs) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axil_reg_read_slave.sv
module tb_axil_reg_read_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b1;
  logic [31:0] araddr = '0;
  logic        arready, rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [255:0] regs_flat;

  logic        arvalid0 = 1'b0, rready0 = 1'b1;
  logic [31:0] araddr0 = '0;
  logic        arready0, rvalid0;
  logic [31:0] rdata0;
  logic [1:0]  rresp0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_reg_read_slave dut (
    .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .regs_flat(regs_flat)
  );

  axil_reg_read_slave #(.READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .arvalid(arvalid0), .arready(arready0), .araddr(araddr0),
    .rvalid(rvalid0), .rready(rready0), .rdata(rdata0), .rresp(rresp0), .regs_flat(regs_flat)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    regs_flat[i*32 +: 32] = v;
  endtask

  // Waits (bounded) for arready, then presents one address for one edge.
  task automatic issue_ar(input logic [31:0] a, output bit ok);
    int n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = arready;
    if (!ok) begin
      chk("arready_timeout", 32'(arready), 32'd1);
    end else begin
      araddr  = a;
      arvalid = 1'b1;
      @(posedge clk);
      #1 arvalid = 1'b0;
    end
  endtask

  // Counts posedges until rvalid is seen at a negedge (bounded).
  task automatic wait_rvalid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!rvalid && lat < 30);
    if (!rvalid) chk("rvalid_timeout", 32'(rvalid), 32'd1);
  endtask

  vec_t vecs[9];
  bit   ok;
  int   lat;

  initial begin
    for (int i = 0; i < 8; i++) set_reg(i, 32'hA000_0000 | (i * 32'h1111));
    set_reg(2, 32'hDEAD_BEEF);

    vecs[0] = '{32'h1000_0008, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{32'h1000_0000, 32'hA000_0000, 2'b00};
    vecs[2] = '{32'h1000_001C, 32'hA000_7777, 2'b00};
    vecs[3] = '{32'h1000_0004, 32'hA000_1111, 2'b00};
    vecs[4] = '{32'h1000_0006, 32'h0000_0000, 2'b10};
    vecs[5] = '{32'h1000_0020, 32'h0000_0000, 2'b10};
    vecs[6] = '{32'h0FFF_FFFC, 32'h0000_0000, 2'b10};
    vecs[7] = '{32'h1000_0001, 32'h0000_0000, 2'b10};
    vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0000, 2'b10};

    // Reset held with arvalid asserted: nothing may be accepted.
    arvalid = 1'b1;
    araddr  = 32'h1000_0008;
    repeat (3) begin
      @(negedge clk);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
    end
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    rst = 1'b0;
    arvalid = 1'b0;
    #1 chk("post_rst_arready_first", 32'(arready), 32'd0);
    @(negedge clk);
    chk("post_rst_arready_second", 32'(arready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("no_hs_from_reset", 32'(rvalid), 32'd0);
    end

    // Table of single reads with rready held high.
    rready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      issue_ar(vecs[v].addr, ok);
      if (ok) begin
        wait_rvalid(lat);
        chk($sformatf("lat_%0d", v), 32'(lat), 32'd3);
        chk($sformatf("rdata_%0d", v), rdata, vecs[v].exp_data);
        chk($sformatf("rresp_%0d", v), 32'(rresp), 32'(vecs[v].exp_resp));
        @(negedge clk);
        chk($sformatf("rvalid_clr_%0d", v), 32'(rvalid), 32'd0);
        chk($sformatf("rdata_clr_%0d", v), rdata, 32'd0);
        chk($sformatf("arready_back_%0d", v), 32'(arready), 32'd1);
      end
    end

    // Backpressure: response held while rready low and reg2 changes.
    rready = 1'b0;
    issue_ar(32'h1000_0008, ok);
    if (ok) begin
      wait_rvalid(lat);
      chk("bp_first_data", rdata, 32'hDEAD_BEEF);
      set_reg(2, 32'h1234_5678);
      repeat (5) begin
        @(negedge clk);
        chk("bp_rvalid_hold", 32'(rvalid), 32'd1);
        chk("bp_rdata_hold", rdata, 32'hDEAD_BEEF);
        chk("bp_arready_low", 32'(arready), 32'd0);
      end
      rready = 1'b1;
      @(negedge clk);
      chk("bp_rvalid_done", 32'(rvalid), 32'd0);
      chk("bp_arready_next", 32'(arready), 32'd1);
    end

    // Data is sampled entering RESP, not at AR acceptance.
    set_reg(3, 32'h1);
    issue_ar(32'h1000_000C, ok);
    if (ok) begin
      @(negedge clk);
      chk("wait_arready_low", 32'(arready), 32'd0);
      set_reg(3, 32'h2);
      wait_rvalid(lat);
      chk("sample_point_data", rdata, 32'h2);
      @(negedge clk);
    end

    // Reset in WAIT: no stale response afterwards.
    issue_ar(32'h1000_0008, ok);
    if (ok) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
        @(negedge clk);
        chk("rst_wait_no_rvalid", 32'(rvalid), 32'd0);
      end
      issue_ar(32'h1000_0014, ok);
      if (ok) begin
        wait_rvalid(lat);
        chk("after_rst_wait_data", rdata, 32'hA000_5555);
        @(negedge clk);
      end
    end

    // Reset in RESP with the response still pending.
    rready = 1'b0;
    issue_ar(32'h1000_0000, ok);
    if (ok) begin
      wait_rvalid(lat);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_resp_rvalid", 32'(rvalid), 32'd0);
      chk("rst_resp_rdata", rdata, 32'd0);
      rst = 1'b0;
      rready = 1'b1;
      repeat (6) begin
        @(negedge clk);
        chk("rst_resp_no_stale", 32'(rvalid), 32'd0);
      end
    end

    // Zero-latency instance: rvalid one edge after AR.
    begin
      int n = 0;
      while (!arready0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("l0_arready", 32'(arready0), 32'd1);
      if (arready0) begin
        araddr0  = 32'h1000_0010;
        arvalid0 = 1'b1;
        @(posedge clk);
        #1 arvalid0 = 1'b0;
        lat = 0;
        do begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end while (!rvalid0 && lat < 30);
        chk("l0_lat", 32'(lat), 32'd1);
        chk("l0_rdata", rdata0, 32'hA000_4444);
        chk("l0_rresp", 32'(rresp0), 32'd0);
        @(negedge clk);
        chk("l0_rvalid_clr", 32'(rvalid0), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
